// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer: state
// encoding, instruction field constants and datapath select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BEQ       = 4'd8,
        ST_BMEM_READ = 4'd9,
        ST_BMEM_CMP  = 4'd10,
        ST_JMEM_READ = 4'd11,
        ST_JMEM_JUMP = 4'd12,
        ST_TRAP      = 4'd13
    } state_t;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BMEM  = 6'b010100;

    // R-type funct field IR[5:0] values that change sequencing
    localparam logic [5:0] FN_JMEM    = 6'b101101;
    localparam logic [5:0] FN_PCTOREG = 6'b010110;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_MDR    = 2'b10;

    // Every control output in one bundle so reset gating is a single mux
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    // States that hold the shared memory port and wait on mem_ready
    function automatic logic is_access_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE) ||
               (s == ST_BMEM_READ) || (s == ST_JMEM_READ);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the memory handshake and flags when the
// wait has reached the timeout limit.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    // Restart on clear, count wait cycles, hold once the limit is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (waiting && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback over a shared memory port, with a sticky trap on illegal
// opcodes and memory timeouts.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       pc_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       trap
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;
    logic   timer_expired;
    logic   in_access;

    // The branch decision on zero is taken in the datapath via pc_write_cond
    logic unused_zero;
    assign unused_zero = zero;

    assign in_access = is_access_state(state_reg);

    // Non-access states hold the timer at zero, so it starts fresh on entry
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_access),
        .waiting (in_access && !mem_ready),
        .expired (timer_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and state-decoded controls; mem_ready beats a same-cycle timeout
    always_comb begin
        state_next = state_reg;
        ctrl       = '0;
        unique case (state_reg)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                if (mem_ready)          state_next = ST_DECODE;
                else if (timer_expired) state_next = ST_TRAP;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                if (opcode == OP_LW || opcode == OP_SW || opcode == OP_BMEM)
                    state_next = ST_MEM_ADDR;
                else if (opcode == OP_RTYPE && funct == FN_JMEM)
                    state_next = ST_JMEM_READ;
                else if (opcode == OP_RTYPE)
                    state_next = ST_R_EXEC;
                else if (opcode == OP_BEQ)
                    state_next = ST_BEQ;
                else
                    state_next = ST_TRAP;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                if (opcode == OP_LW)        state_next = ST_MEM_READ;
                else if (opcode == OP_SW)   state_next = ST_MEM_WRITE;
                else if (opcode == OP_BMEM) state_next = ST_BMEM_READ;
                else                        state_next = ST_TRAP;
            end
            ST_MEM_READ, ST_BMEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (mem_ready)
                    state_next = (state_reg == ST_MEM_READ) ? ST_MEM_WB : ST_BMEM_CMP;
                else if (timer_expired)
                    state_next = ST_TRAP;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
                if (mem_ready)          state_next = ST_FETCH;
                else if (timer_expired) state_next = ST_TRAP;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_next     = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.pc_to_reg  = (funct == FN_PCTOREG);
                ctrl.instr_done = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_BEQ, ST_BMEM_CMP: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                state_next         = ST_FETCH;
            end
            ST_JMEM_READ: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                if (mem_ready)          state_next = ST_JMEM_JUMP;
                else if (timer_expired) state_next = ST_TRAP;
            end
            ST_JMEM_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_MDR;
                ctrl.instr_done = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: begin
                state_next = ST_TRAP;
            end
        endcase
    end

    // Reset forces every control low immediately, even mid-access
    assign ctrl_out = rst_n ? ctrl : '0;

    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign iord          = ctrl_out.iord;
    assign ir_write      = ctrl_out.ir_write;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign pc_to_reg     = ctrl_out.pc_to_reg;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_source     = ctrl_out.pc_source;
    assign instr_done    = ctrl_out.instr_done;
    assign trap          = ctrl_out.trap;

endmodule
